snake_dir_ctrl: RTL

// - Consumes the one-cycle key-press pulses produced by the per-button input

---
 rtl/snake_pkg.sv | 18 +
 rtl/snake_turn_fifo.sv | 68 ++++++
 rtl/snake_dir_ctrl.sv | 84 ++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared heading type and helpers for the snake direction controller and the board logic.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    localparam int unsigned MAX_QDEPTH = 4;

    // Opposite headings differ only in bit 1.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_turn_fifo.sv
// Small circular FIFO of pending turns; push and pop may coincide at any fill level.
module snake_turn_fifo
    import snake_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  dir_t       din,
    output dir_t       dout,
    output dir_t       tail,
    output logic [2:0] count,
    output logic       full,
    output logic       empty
);

    localparam logic [1:0] LAST = 2'(QDEPTH - 1);

    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    dir_t       mem [MAX_QDEPTH];
    logic       do_push;
    logic       do_pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign empty   = (count == 3'd0);
    assign full    = (count == 3'(QDEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full queue needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign tail    = mem[(wr_ptr == 2'd0) ? LAST : wr_ptr - 2'd1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < MAX_QDEPTH; i++) begin
                mem[i] <= UP;
            end
        end else if (clear) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + 3'd1;
            end else if (!do_push && do_pop) begin
                count <= count - 3'd1;
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake heading controller: selects one key press, rejects repeats/reversals,
// queues accepted turns and applies one per game tick.
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned QDEPTH   = 2,
    parameter dir_t        INIT_DIR = RIGHT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       up_p,
    input  logic       down_p,
    input  logic       left_p,
    input  logic       right_p,
    input  logic       tick,
    output dir_t       dir,
    output logic       step,
    output logic [2:0] qcount,
    output logic       drop
);

    logic press;
    dir_t cand;
    dir_t ref_dir;
    logic accept;
    logic push;
    dir_t q_head;
    dir_t q_tail;
    logic q_full;
    logic q_empty;

    always_comb begin
        press = up_p | down_p | left_p | right_p;
        cand  = RIGHT;
        if (up_p) begin
            cand = UP;
        end else if (down_p) begin
            cand = DOWN;
        end else if (left_p) begin
            cand = LEFT;
        end
    end

    // Validate against the newest pending turn, not the heading, so chained turns work.
    assign ref_dir = q_empty ? dir : q_tail;
    assign accept  = press && (cand != ref_dir) && (cand != reverse_dir(ref_dir));
    assign push    = accept && (!q_full || tick);

    snake_turn_fifo #(
        .QDEPTH(QDEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .push (push),
        .pop  (tick),
        .din  (cand),
        .dout (q_head),
        .tail (q_tail),
        .count(qcount),
        .full (q_full),
        .empty(q_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir  <= INIT_DIR;
            step <= 1'b0;
            drop <= 1'b0;
        end else if (clear) begin
            dir  <= INIT_DIR;
            step <= 1'b0;
            drop <= 1'b0;
        end else begin
            step <= tick;
            drop <= press && !push;
            if (tick && !q_empty) begin
                dir <= q_head;
            end
        end
    end

endmodule
